// File: rtl/mem_controller_pkg.sv
// Shared definitions for the memory controller: FSM state encodings, requester tags
// and the uncached access size codes with their byte counts.
package mem_controller_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      IC_RD = 3'd1,
      DC_RD = 3'd2,
      DC_WR = 3'd3,
      IO_RD = 3'd4,
      IO_WR = 3'd5,
      RESP  = 3'd6
   } ctrlState_t;

   typedef enum logic [1:0] {
      SRC_NONE = 2'd0,
      SRC_IC   = 2'd1,
      SRC_DC   = 2'd2,
      SRC_IO   = 2'd3
   } reqSrc_t;

   localparam logic [1:0] IO_SIZE_NONE = 2'b00;
   localparam logic [1:0] IO_SIZE_BYTE = 2'b01;
   localparam logic [1:0] IO_SIZE_HALF = 2'b10;
   localparam logic [1:0] IO_SIZE_WORD = 2'b11;

   function automatic logic [2:0] ioBytes(input logic [1:0] size);
      case (size)
         IO_SIZE_BYTE: ioBytes = 3'd1;
         IO_SIZE_HALF: ioBytes = 3'd2;
         IO_SIZE_WORD: ioBytes = 3'd4;
         default:      ioBytes = 3'd0;
      endcase
   endfunction

endpackage

// File: rtl/line_shifter.sv
// Line buffer for one transfer: loads a whole line for serialisation, or assembles
// a line one byte at a time (little-endian) from RAM read data.
module line_shifter #(
   parameter int BLOCK_WIDTH = 4,
   parameter int BLOCK_SIZE  = 2**BLOCK_WIDTH
) (
   input  logic                    clkIn,
   input  logic                    resetIn,
   input  logic                    loadEn,
   input  logic [BLOCK_SIZE*8-1:0] loadData,
   input  logic                    captureEn,
   input  logic [BLOCK_WIDTH-1:0]  captureIdx,
   input  logic [7:0]              captureByte,
   input  logic [BLOCK_WIDTH-1:0]  readIdx,
   output logic [BLOCK_SIZE*8-1:0] lineData,
   output logic [7:0]              readByte
);

   genvar gi;
   generate
      for (gi = 0; gi < BLOCK_SIZE; gi++) begin : g_byte
         logic [7:0] byteReg;

         always_ff @(posedge clkIn) begin
            if (resetIn) begin
               byteReg <= 8'h00;
            end else if (loadEn) begin
               byteReg <= loadData[8*gi +: 8];
            end else if (captureEn && (captureIdx == BLOCK_WIDTH'(gi))) begin
               byteReg <= captureByte;
            end
         end

         assign lineData[8*gi +: 8] = byteReg;
      end
   endgenerate

   assign readByte = lineData[8*readIdx +: 8];

endmodule

// File: rtl/mem_controller.sv
// Byte-serial RAM arbiter for ICache fills, DCache fills/writebacks and uncached IO.
// One request is granted at a time (io > dc > ic) and completes with a done pulse.
module mem_controller
   import mem_controller_pkg::*;
#(
   parameter int BLOCK_WIDTH = 4,
   parameter int BLOCK_SIZE  = 2**BLOCK_WIDTH
) (
   input  logic                    clkIn,
   input  logic                    resetIn,
   input  logic                    readyIn,
   input  logic                    clearIn,
   input  logic [7:0]              memIn,
   output logic [7:0]              memOut,
   output logic [31:0]             memAddr,
   output logic                    memWrite,
   input  logic                    icReq,
   input  logic [31-BLOCK_WIDTH:0] icAddr,
   output logic                    icDone,
   output logic [BLOCK_SIZE*8-1:0] icData,
   input  logic                    dcReq,
   input  logic                    dcWrite,
   input  logic [31-BLOCK_WIDTH:0] dcAddr,
   input  logic [BLOCK_SIZE*8-1:0] dcWData,
   output logic                    dcDone,
   output logic [BLOCK_SIZE*8-1:0] dcRData,
   input  logic                    ioReq,
   input  logic                    ioWrite,
   input  logic [1:0]              ioSize,
   input  logic [31:0]             ioAddr,
   input  logic [31:0]             ioWData,
   output logic                    ioDone,
   output logic [31:0]             ioRData
);

   localparam int CW = BLOCK_WIDTH + 1;
   localparam int LW = BLOCK_SIZE * 8;

   ctrlState_t stateReg, stateNext;
   reqSrc_t    srcReg, srcNext;
   logic [31:0]   baseReg, baseNext;
   logic [CW-1:0] cntReg, cntNext;
   logic [CW-1:0] lenReg, lenNext;

   logic          grant;
   logic          readSt, writeSt, addrActive, captureEn;
   logic [LW-1:0] loadData, lineData;
   logic [7:0]    txByte;

   always_ff @(posedge clkIn) begin
      if (resetIn) begin
         stateReg <= IDLE;
         srcReg   <= SRC_NONE;
         baseReg  <= 32'h0;
         cntReg   <= '0;
         lenReg   <= '0;
      end else begin
         stateReg <= stateNext;
         srcReg   <= srcNext;
         baseReg  <= baseNext;
         cntReg   <= cntNext;
         lenReg   <= lenNext;
      end
   end

   // Operands are captured at grant; the counter only runs while a transfer stays
   // in its state, so leaving a transfer always returns it to zero.
   always_comb begin
      stateNext = stateReg;
      srcNext   = srcReg;
      baseNext  = baseReg;
      lenNext   = lenReg;
      cntNext   = '0;
      grant     = 1'b0;
      loadData  = '0;
      case (stateReg)
         IDLE: begin
            if (readyIn) begin
               if (ioReq) begin
                  grant    = 1'b1;
                  srcNext  = SRC_IO;
                  baseNext = ioAddr;
                  lenNext  = CW'(ioBytes(ioSize));
                  if (ioWrite) loadData = LW'(ioWData);
                  if (ioSize == IO_SIZE_NONE) stateNext = RESP;
                  else stateNext = ioWrite ? IO_WR : IO_RD;
               end else if (dcReq) begin
                  grant     = 1'b1;
                  srcNext   = SRC_DC;
                  baseNext  = {dcAddr, {BLOCK_WIDTH{1'b0}}};
                  lenNext   = CW'(BLOCK_SIZE);
                  if (dcWrite) loadData = dcWData;
                  stateNext = dcWrite ? DC_WR : DC_RD;
               end else if (icReq) begin
                  grant     = 1'b1;
                  srcNext   = SRC_IC;
                  baseNext  = {icAddr, {BLOCK_WIDTH{1'b0}}};
                  lenNext   = CW'(BLOCK_SIZE);
                  stateNext = IC_RD;
               end
            end
         end
         // Reads linger one extra cycle to catch the last byte returning from RAM.
         IC_RD, DC_RD, IO_RD: begin
            if ((stateReg == IC_RD) && clearIn) stateNext = IDLE;
            else if (cntReg == lenReg) stateNext = RESP;
            else cntNext = cntReg + 1'b1;
         end
         DC_WR, IO_WR: begin
            if (cntReg == lenReg - 1'b1) stateNext = RESP;
            else cntNext = cntReg + 1'b1;
         end
         RESP:    stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   always_comb begin
      readSt     = stateReg inside {IC_RD, DC_RD, IO_RD};
      writeSt    = stateReg inside {DC_WR, IO_WR};
      addrActive = (readSt || writeSt) && (cntReg < lenReg);
      captureEn  = readSt && (cntReg != '0);
      memAddr    = addrActive ? (baseReg + 32'(cntReg)) : 32'h0;
      memWrite   = writeSt;
      memOut     = writeSt ? txByte : 8'h00;
      icDone     = (stateReg == RESP) && (srcReg == SRC_IC);
      dcDone     = (stateReg == RESP) && (srcReg == SRC_DC);
      ioDone     = (stateReg == RESP) && (srcReg == SRC_IO);
   end

   // Byte returning in this cycle was addressed with the previous count.
   line_shifter #(
      .BLOCK_WIDTH(BLOCK_WIDTH),
      .BLOCK_SIZE (BLOCK_SIZE)
   ) u_shifter (
      .clkIn      (clkIn),
      .resetIn    (resetIn),
      .loadEn     (grant),
      .loadData   (loadData),
      .captureEn  (captureEn),
      .captureIdx (cntReg[BLOCK_WIDTH-1:0] - 1'b1),
      .captureByte(memIn),
      .readIdx    (cntReg[BLOCK_WIDTH-1:0]),
      .lineData   (lineData),
      .readByte   (txByte)
   );

   assign icData  = lineData;
   assign dcRData = lineData;
   assign ioRData = lineData[31:0];

endmodule

// File: tb/tb_mem_controller.sv
// Directed bench for mem_controller: line fill, writeback, IO read, arbitration,
// flush abort, readyIn gating and mid-transfer reset against hand-computed values.
module tb_mem_controller;

   logic         clkIn = 1'b0;
   logic         resetIn, readyIn, clearIn;
   logic [7:0]   memIn, memOut;
   logic [31:0]  memAddr;
   logic         memWrite;
   logic         icReq, icDone;
   logic [27:0]  icAddr;
   logic [127:0] icData;
   logic         dcReq, dcWrite, dcDone;
   logic [27:0]  dcAddr;
   logic [127:0] dcWData, dcRData;
   logic         ioReq, ioWrite, ioDone;
   logic [1:0]   ioSize;
   logic [31:0]  ioAddr, ioWData, ioRData;

   int vecCount  = 0;
   int missCount = 0;

   logic [7:0] ram [0:262143];

   localparam logic [127:0] IC_LINE = 128'h0F0E0D0C0B0A09080706050403020100;
   localparam logic [127:0] DC_LINE = 128'h5F5E5D5C5B5A59585756555453525150;

   mem_controller #(.BLOCK_WIDTH(4)) dut (
      .clkIn(clkIn), .resetIn(resetIn), .readyIn(readyIn), .clearIn(clearIn),
      .memIn(memIn), .memOut(memOut), .memAddr(memAddr), .memWrite(memWrite),
      .icReq(icReq), .icAddr(icAddr), .icDone(icDone), .icData(icData),
      .dcReq(dcReq), .dcWrite(dcWrite), .dcAddr(dcAddr), .dcWData(dcWData),
      .dcDone(dcDone), .dcRData(dcRData),
      .ioReq(ioReq), .ioWrite(ioWrite), .ioSize(ioSize), .ioAddr(ioAddr),
      .ioWData(ioWData), .ioDone(ioDone), .ioRData(ioRData)
   );

   always #5 clkIn = ~clkIn;

   // RAM answers one cycle after the address.
   always @(posedge clkIn) memIn <= ram[memAddr[17:0]];

   task automatic checkValue(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      vecCount++;
      if (obs !== exp) begin
         missCount++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clkIn);
      #1;
   endtask

   task automatic checkQuiet(input string tag);
      checkValue(tag, 128'({memAddr, memOut, memWrite, icDone, dcDone, ioDone}), 128'h0);
   endtask

   task automatic runIc(input logic [27:0] a, input logic [127:0] expData);
      int doneAt = -1;
      icAddr = a;
      icReq  = 1'b1;
      for (int c = 1; c <= 20; c++) begin
         tick();
         if (c <= 16) begin
            checkValue("ic_addr", 128'(memAddr), 128'({a, 4'(c - 1)}));
            checkValue("ic_rd_we", 128'(memWrite), 128'h0);
         end else begin
            checkValue("ic_addr_idle", 128'(memAddr), 128'h0);
         end
         checkValue("ic_done", 128'(icDone), 128'(c == 18));
         if (icDone) begin
            checkValue("ic_data", icData, expData);
            icReq  = 1'b0;
            doneAt = c;
         end
      end
      $display("ic fill line 0x%07h: icDone at cycle %0d", a, doneAt);
   endtask

   initial begin
      int icN, dcN, ioN, icAt, dcAt, ioAt, seen;

      for (int k = 0; k < 16; k++) begin
         ram[18'h01000 + 18'(k)] = 8'(k);
         ram[18'h04000 + 18'(k)] = 8'(8'h50 + k);
      end
      ram[18'h30004] = 8'h11;
      ram[18'h30005] = 8'h22;
      ram[18'h30006] = 8'h33;
      ram[18'h30007] = 8'h44;

      resetIn = 1'b1; readyIn = 1'b1; clearIn = 1'b0;
      icReq = 1'b0; icAddr = '0;
      dcReq = 1'b0; dcWrite = 1'b0; dcAddr = '0; dcWData = '0;
      ioReq = 1'b0; ioWrite = 1'b0; ioSize = 2'b00; ioAddr = '0; ioWData = '0;
      tick();
      tick();
      checkQuiet("reset_ctrl");
      checkValue("reset_data", icData | dcRData | 128'(ioRData), 128'h0);
      resetIn = 1'b0;
      tick();
      $display("reset: outputs quiet");

      // ICache fill of line 0x0000100
      runIc(28'h0000100, IC_LINE);

      // DCache writeback; readyIn drop mid-transfer must not matter
      for (int k = 0; k < 16; k++) dcWData[8*k +: 8] = 8'(8'hA0 + k);
      dcAddr = 28'h0000200; dcWrite = 1'b1; dcReq = 1'b1;
      seen = -1;
      for (int c = 1; c <= 19; c++) begin
         tick();
         if (c == 3) readyIn = 1'b0;
         if (c == 6) readyIn = 1'b1;
         if (c <= 16) begin
            checkValue("dc_wr_addr", 128'(memAddr), 128'(32'h2000 + c - 1));
            checkValue("dc_wr_we", 128'(memWrite), 128'h1);
            checkValue("dc_wr_data", 128'(memOut), 128'(8'(8'hA0 + c - 1)));
         end else begin
            checkValue("dc_wr_we_off", 128'({memWrite, memAddr, memOut}), 128'h0);
         end
         checkValue("dc_wr_done", 128'(dcDone), 128'(c == 17));
         if (dcDone) begin
            dcReq = 1'b0;
            seen  = c;
         end
      end
      dcWrite = 1'b0;
      $display("dc writeback line 0x0000200: dcDone at cycle %0d", seen);

      // IO word read at 0x30004
      ioAddr = 32'h30004; ioSize = 2'b11; ioWrite = 1'b0; ioReq = 1'b1;
      seen = -1;
      for (int c = 1; c <= 8; c++) begin
         tick();
         if (c <= 4) checkValue("io_rd_addr", 128'(memAddr), 128'(32'h30004 + c - 1));
         checkValue("io_rd_done", 128'(ioDone), 128'(c == 6));
         if (ioDone) begin
            checkValue("io_rd_data", 128'(ioRData), 128'h44332211);
            ioReq = 1'b0;
            seen  = c;
         end
      end
      $display("io word read 0x30004: ioDone at cycle %0d", seen);

      // Simultaneous requests: io byte write, dc fill, ic fill
      ioAddr = 32'h30010; ioSize = 2'b01; ioWrite = 1'b1; ioWData = 32'hFFFFFF5A;
      dcAddr = 28'h0000400; dcWrite = 1'b0;
      icAddr = 28'h0000100;
      ioReq = 1'b1; dcReq = 1'b1; icReq = 1'b1;
      icN = 0; dcN = 0; ioN = 0; icAt = -1; dcAt = -1; ioAt = -1;
      for (int c = 1; c <= 45; c++) begin
         tick();
         if (c == 1) checkValue("arb_io_wr", 128'({memWrite, memAddr, memOut}), 128'({1'b1, 32'h30010, 8'h5A}));
         if (ioDone) begin ioN++; ioAt = c; ioReq = 1'b0; end
         if (dcDone) begin
            dcN++; dcAt = c; dcReq = 1'b0;
            checkValue("arb_dc_data", dcRData, DC_LINE);
         end
         if (icDone) begin
            icN++; icAt = c; icReq = 1'b0;
            checkValue("arb_ic_data", icData, IC_LINE);
         end
      end
      checkValue("arb_done_counts", 128'({8'(ioN), 8'(dcN), 8'(icN)}), 128'h010101);
      checkValue("arb_done_cycles", 128'({8'(ioAt), 8'(dcAt), 8'(icAt)}), 128'({8'd2, 8'd21, 8'd40}));
      ioWrite = 1'b0;
      $display("arbitration: io done %0d, dc done %0d, ic done %0d", ioAt, dcAt, icAt);

      // Flush in cycle 5 of an ICache fill
      icAddr = 28'h0000100; icReq = 1'b1;
      for (int c = 1; c <= 5; c++) tick();
      checkValue("clr_addr_c5", 128'(memAddr), 128'h1004);
      clearIn = 1'b1; icReq = 1'b0;
      tick();
      clearIn = 1'b0;
      checkQuiet("clr_idle");
      seen = 0;
      for (int c = 0; c < 24; c++) begin
         tick();
         if (icDone) seen++;
      end
      checkValue("clr_no_done", 128'(seen), 128'h0);
      $display("ic fill flushed at cycle 5: %0d icDone pulses", seen);
      runIc(28'h0000100, IC_LINE);

      // readyIn low blocks the grant until raised
      readyIn = 1'b0; icAddr = 28'h0000100; icReq = 1'b1;
      for (int c = 0; c < 6; c++) begin
         tick();
         checkQuiet("nogrant");
      end
      $display("readyIn low: no grant over 6 cycles");
      readyIn = 1'b1;
      runIc(28'h0000100, IC_LINE);

      // Reset in cycle 8 of a writeback
      dcAddr = 28'h0000200; dcWrite = 1'b1; dcReq = 1'b1;
      for (int c = 1; c <= 8; c++) tick();
      checkValue("rst_pre_addr", 128'(memAddr), 128'h2007);
      resetIn = 1'b1; dcReq = 1'b0;
      tick();
      resetIn = 1'b0;
      checkQuiet("rst_ctrl");
      checkValue("rst_data", icData | dcRData | 128'(ioRData), 128'h0);
      seen = 0;
      for (int c = 0; c < 25; c++) begin
         tick();
         if (dcDone) seen++;
      end
      checkValue("rst_no_done", 128'(seen), 128'h0);
      $display("reset during writeback: %0d dcDone pulses", seen);

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded its time budget");
      $fatal(1, "timeout");
   end

endmodule
